mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and GPU single-word accesses onto one
// mem_controller request/ack port, with a bounded wait for read data.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_done, cpu_rdata CPU grant pulse, completion pulse, read data
//   gpu_*                        same as cpu_*, GPU side
//   mem_req/we/addr/wdata        request to mem_controller (held until mem_ack)
//   mem_ack, mem_rvalid, mem_rdata  mem_controller responses
//   err                          pulses with *_done when a read timed out
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate the grant on
// simultaneous requests; otherwise the CPU has fixed priority.

module mem_arbiter #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_done,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic        OWN_CPU = 1'b0;
  localparam logic        OWN_GPU = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               cpu_gnt_q, cpu_gnt_d, gpu_gnt_q, gpu_gnt_d;
  logic               cpu_done_q, cpu_done_d, gpu_done_q, gpu_done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d, gpu_rdata_q, gpu_rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_gpu;

  // Arbitration: which requester wins when sampled in IDLE
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign grant_gpu = gpu_req & (~cpu_req | (last_q == OWN_CPU));
`else
  assign grant_gpu = gpu_req & ~cpu_req;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_gnt_d   = 1'b0;
    gpu_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    gpu_done_d  = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    gpu_rdata_d = gpu_rdata_q;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || gpu_req) begin
          state_d     = ISSUE;
          owner_d     = grant_gpu ? OWN_GPU : OWN_CPU;
          cpu_gnt_d   = ~grant_gpu;
          gpu_gnt_d   = grant_gpu;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_gpu ? gpu_we    : cpu_we;
          mem_addr_d  = grant_gpu ? gpu_addr  : cpu_addr;
          mem_wdata_d = grant_gpu ? gpu_wdata : cpu_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d      = grant_gpu ? OWN_GPU : OWN_CPU;
`endif
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d    = IDLE;
            cpu_done_d = (owner_q == OWN_CPU);
            gpu_done_d = (owner_q == OWN_GPU);
          end else begin
            state_d = WAIT_RD;
            cnt_d   = '0;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          cpu_done_d = (owner_q == OWN_CPU);
          gpu_done_d = (owner_q == OWN_GPU);
          if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
          else                    gpu_rdata_d = mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // Timed out: complete with zero data and flag the error
          state_d    = IDLE;
          cpu_done_d = (owner_q == OWN_CPU);
          gpu_done_d = (owner_q == OWN_GPU);
          err_d      = 1'b1;
          if (owner_q == OWN_CPU) cpu_rdata_d = '0;
          else                    gpu_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      gpu_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      gpu_done_q  <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      gpu_rdata_q <= '0;
      cnt_q       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= OWN_GPU;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      gpu_gnt_q   <= gpu_gnt_d;
      cpu_done_q  <= cpu_done_d;
      gpu_done_q  <= gpu_done_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      gpu_rdata_q <= gpu_rdata_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign gpu_gnt   = gpu_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign gpu_done  = gpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign gpu_rdata = gpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
